sram_rr_arbiter: RTL

Single-clock, parametrised SRAM front end. It arbitrates NUM_WR write channels and NUM_RD read channels onto one SRAM command port using fair round-robin. Read responses return in order and are steered to the issuing channel's return FIFO by an in-flight tag queue. Per-channel credit accounting gives true read backpressure, so return data is never dropped. It replaces the fixed four-state, fixed-latency arbiter for designs needing more ports, variable widths and read-side flow control.

---
 rtl/sram_arb_pkg.sv | 39 +++
 rtl/sram_rr_arbiter_if.sv | 44 ++++
 rtl/sram_arb_fifo.sv | 55 +++++
 rtl/sram_rr_arbiter.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
// Shared width helpers and {mask,addr,data} field offsets for the SRAM arbiter.
package sram_arb_pkg;

    // Data sits in the low bits of each write slice, then address, then mask.
    localparam int FLD_DATA_LO = 0;

    // Ceiling log2; returns 0 for v <= 1.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Ceiling log2 clamped to at least one bit, for index/tag fields.
    function automatic int clog2_min1(input int v);
        int r;
        r = clog2(v);
        return (r < 1) ? 1 : r;
    endfunction

    // Low bit of channel idx inside a flattened bus of width-bit slices.
    function automatic int slice_lo(input int idx, input int width);
        return idx * width;
    endfunction

    function automatic int fld_addr_lo(input int data_w);
        return data_w;
    endfunction

    function automatic int fld_mask_lo(input int data_w, input int addr_w);
        return data_w + addr_w;
    endfunction

endpackage

// File: rtl/sram_rr_arbiter_if.sv
// Client channels and SRAM command/response port of the round-robin arbiter.
interface sram_rr_arbiter_if #(
    parameter int NUM_WR = 2,
    parameter int NUM_RD = 2,
    parameter int ADDR_W = 18,
    parameter int DATA_W = 32
) ();
    localparam int MASK_W = DATA_W / 8;
    localparam int WR_W   = MASK_W + ADDR_W + DATA_W;

    logic [NUM_WR-1:0]        wr_valid;
    logic [NUM_WR-1:0]        wr_ready;
    logic [NUM_WR*WR_W-1:0]   wr_din;
    logic [NUM_RD-1:0]        rd_addr_valid;
    logic [NUM_RD-1:0]        rd_addr_ready;
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD-1:0]        rd_dout_valid;
    logic [NUM_RD-1:0]        rd_dout_ready;
    logic [NUM_RD*DATA_W-1:0] rd_dout;
    logic                     sram_ready;
    logic                     sram_addr_valid;
    logic [ADDR_W-1:0]        sram_addr;
    logic [DATA_W-1:0]        sram_data_in;
    logic [MASK_W-1:0]        sram_write_mask;
    logic [DATA_W-1:0]        sram_data_out;
    logic                     sram_data_out_valid;
    logic                     rsp_orphan;

    // Arbiter side.
    modport slave (
        input  wr_valid, wr_din, rd_addr_valid, rd_addr, rd_dout_ready,
               sram_ready, sram_data_out, sram_data_out_valid,
        output wr_ready, rd_addr_ready, rd_dout_valid, rd_dout,
               sram_addr_valid, sram_addr, sram_data_in, sram_write_mask, rsp_orphan
    );

    // Clients plus SRAM side.
    modport master (
        output wr_valid, wr_din, rd_addr_valid, rd_addr, rd_dout_ready,
               sram_ready, sram_data_out, sram_data_out_valid,
        input  wr_ready, rd_addr_ready, rd_dout_valid, rd_dout,
               sram_addr_valid, sram_addr, sram_data_in, sram_write_mask, rsp_orphan
    );
endinterface

// File: rtl/sram_arb_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count (DEPTH power of 2, >= 2).
module sram_arb_fifo
    import sram_arb_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    push_i,
    input  logic [WIDTH-1:0]        din_i,
    input  logic                    pop_i,
    output logic [WIDTH-1:0]        dout_o,
    output logic [clog2(DEPTH):0]   count_o
);
    localparam int AW = clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    // Full pushes and empty pops are ignored; pointers wrap naturally.
    always_comb begin
        do_push  = push_i && (count_q != CW'(DEPTH));
        do_pop   = pop_i && (count_q != '0);
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
    end

    // Control state; storage is left unreset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage write.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    assign dout_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
endmodule

// File: rtl/sram_rr_arbiter.sv
// Round-robin SRAM front end: NUM_WR write and NUM_RD read channels share one
// command port; in-order read data is steered back through a tag queue into
// per-channel return FIFOs guarded by credit counters.
module sram_rr_arbiter
    import sram_arb_pkg::*;
#(
    parameter int NUM_WR       = 2,
    parameter int NUM_RD       = 2,
    parameter int ADDR_W       = 18,
    parameter int DATA_W       = 32,
    parameter int MAX_INFLIGHT = 4,
    parameter int RET_DEPTH    = 4
) (
    input  logic             sram_clock,
    input  logic             reset,
    sram_rr_arbiter_if.slave bus
);
    localparam int MASK_W = DATA_W / 8;
    localparam int WR_W   = MASK_W + ADDR_W + DATA_W;
    localparam int N      = NUM_WR + NUM_RD;
    localparam int PTR_W  = clog2_min1(N);
    localparam int TAG_W  = clog2_min1(NUM_RD);
    localparam int CNT_W  = clog2(RET_DEPTH) + 1;
    localparam int TQ_CW  = clog2(MAX_INFLIGHT) + 1;

    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [N-1:0]      elig, gnt_oh;
    logic              gnt_vld;
    logic [PTR_W-1:0]  gnt_idx;

    logic              cmd_vld_q, cmd_vld_d;
    logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
    logic [DATA_W-1:0] cmd_data_q, cmd_data_d;
    logic [MASK_W-1:0] cmd_mask_q, cmd_mask_d;
    logic              orphan_q, orphan_d;

    logic              tq_push, tq_pop, tq_empty, tq_full;
    logic [TAG_W-1:0]  tq_din, tq_dout;
    logic [TQ_CW-1:0]  tq_count;

    logic [NUM_RD-1:0] ret_push, ret_pop, ret_vld;
    logic [DATA_W-1:0] ret_dout  [NUM_RD];
    logic [CNT_W-1:0]  ret_count [NUM_RD];
    logic [CNT_W-1:0]  inflight_q [NUM_RD];
    logic [CNT_W-1:0]  inflight_d [NUM_RD];
    logic [CNT_W:0]    credit_use [NUM_RD];

    assign tq_empty = (tq_count == '0);
    assign tq_full  = (tq_count == TQ_CW'(MAX_INFLIGHT));

    // Eligibility: reads need a free tag and a guaranteed return-FIFO slot.
    always_comb begin
        elig = '0;
        for (int i = 0; i < NUM_WR; i++) begin
            elig[i] = bus.wr_valid[i];
        end
        for (int j = 0; j < NUM_RD; j++) begin
            credit_use[j] = {1'b0, inflight_q[j]} + {1'b0, ret_count[j]};
            elig[NUM_WR+j] = bus.rd_addr_valid[j] && !tq_full &&
                             (credit_use[j] < (CNT_W+1)'(RET_DEPTH));
        end
    end

    // Grant the first eligible requester at or after ptr, cyclically.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        gnt_oh  = '0;
        if (bus.sram_ready) begin
            for (int off = 0; off < N; off++) begin
                for (int i = 0; i < N; i++) begin
                    if (!gnt_vld && elig[i] &&
                        ((int'(ptr_q) + off == i) || (int'(ptr_q) + off == i + N))) begin
                        gnt_vld   = 1'b1;
                        gnt_idx   = PTR_W'(i);
                        gnt_oh[i] = 1'b1;
                    end
                end
            end
        end
        ptr_d = ptr_q;
        if (gnt_vld) begin
            ptr_d = (int'(gnt_idx) == N - 1) ? '0 : gnt_idx + PTR_W'(1);
        end
    end

    assign bus.wr_ready      = gnt_oh[NUM_WR-1:0];
    assign bus.rd_addr_ready = gnt_oh[N-1:NUM_WR];

    // Next command from the winner; fields hold when nothing is granted.
    always_comb begin
        cmd_vld_d  = gnt_vld;
        cmd_addr_d = cmd_addr_q;
        cmd_data_d = cmd_data_q;
        cmd_mask_d = cmd_mask_q;
        tq_push    = 1'b0;
        tq_din     = '0;
        for (int i = 0; i < NUM_WR; i++) begin
            if (gnt_oh[i]) begin
                cmd_data_d = bus.wr_din[slice_lo(i, WR_W) + FLD_DATA_LO +: DATA_W];
                cmd_addr_d = bus.wr_din[slice_lo(i, WR_W) + fld_addr_lo(DATA_W) +: ADDR_W];
                cmd_mask_d = bus.wr_din[slice_lo(i, WR_W) + fld_mask_lo(DATA_W, ADDR_W) +: MASK_W];
            end
        end
        for (int j = 0; j < NUM_RD; j++) begin
            if (gnt_oh[NUM_WR+j]) begin
                cmd_addr_d = bus.rd_addr[slice_lo(j, ADDR_W) +: ADDR_W];
                cmd_data_d = '0;
                cmd_mask_d = '0;
                tq_push    = 1'b1;
                tq_din     = TAG_W'(j);
            end
        end
    end

    // Response steering and credit bookkeeping; issue and return may coincide.
    always_comb begin
        tq_pop   = bus.sram_data_out_valid && !tq_empty;
        orphan_d = orphan_q || (bus.sram_data_out_valid && tq_empty);
        for (int j = 0; j < NUM_RD; j++) begin
            ret_push[j]   = tq_pop && (tq_dout == TAG_W'(j));
            ret_vld[j]    = (ret_count[j] != '0);
            ret_pop[j]    = ret_vld[j] && bus.rd_dout_ready[j];
            inflight_d[j] = inflight_q[j];
            if ((tq_push && tq_din == TAG_W'(j)) && !ret_push[j]) begin
                inflight_d[j] = inflight_q[j] + CNT_W'(1);
            end else if (ret_push[j] && !(tq_push && tq_din == TAG_W'(j))) begin
                inflight_d[j] = inflight_q[j] - CNT_W'(1);
            end
        end
    end

    // Return-path outputs.
    always_comb begin
        bus.rd_dout_valid = ret_vld;
        bus.rd_dout       = '0;
        for (int j = 0; j < NUM_RD; j++) begin
            bus.rd_dout[slice_lo(j, DATA_W) +: DATA_W] = ret_dout[j];
        end
    end

    // Pointer, command register, orphan flag and in-flight counters.
    always_ff @(posedge sram_clock) begin
        if (reset) begin
            ptr_q      <= '0;
            cmd_vld_q  <= 1'b0;
            cmd_addr_q <= '0;
            cmd_data_q <= '0;
            cmd_mask_q <= '0;
            orphan_q   <= 1'b0;
            for (int j = 0; j < NUM_RD; j++) begin
                inflight_q[j] <= '0;
            end
        end else begin
            ptr_q      <= ptr_d;
            cmd_vld_q  <= cmd_vld_d;
            cmd_addr_q <= cmd_addr_d;
            cmd_data_q <= cmd_data_d;
            cmd_mask_q <= cmd_mask_d;
            orphan_q   <= orphan_d;
            for (int j = 0; j < NUM_RD; j++) begin
                inflight_q[j] <= inflight_d[j];
            end
        end
    end

    assign bus.sram_addr_valid = cmd_vld_q;
    assign bus.sram_addr       = cmd_addr_q;
    assign bus.sram_data_in    = cmd_data_q;
    assign bus.sram_write_mask = cmd_mask_q;
    assign bus.rsp_orphan      = orphan_q;

    sram_arb_fifo #(.WIDTH(TAG_W), .DEPTH(MAX_INFLIGHT)) u_tag_q (
        .clk_i  (sram_clock),
        .rst_i  (reset),
        .push_i (tq_push),
        .din_i  (tq_din),
        .pop_i  (tq_pop),
        .dout_o (tq_dout),
        .count_o(tq_count)
    );

    for (genvar g = 0; g < NUM_RD; g++) begin : g_ret
        sram_arb_fifo #(.WIDTH(DATA_W), .DEPTH(RET_DEPTH)) u_ret_q (
            .clk_i  (sram_clock),
            .rst_i  (reset),
            .push_i (ret_push[g]),
            .din_i  (bus.sram_data_out),
            .pop_i  (ret_pop[g]),
            .dout_o (ret_dout[g]),
            .count_o(ret_count[g])
        );
    end
endmodule
